mmio_req_queue: RTL and testbench
=================================

MMIO_REQ_QUEUE -- requirements
Module: mmio_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries; power of 2, range 2..16.
REQ-002 Parameter TIMEOUT, default 1023, maximum cycles to wait for a read response.
REQ-003 clock  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 lsu_req_in  input  device_req_t  LSU MMIO request; its valid field is the push strobe.
REQ-006 lsu_req_ready  output  1  FIFO can accept a request this cycle.
REQ-007 dev_req_out  output  device_req_t  request to PLIC (PLIC forwards UART-range requests); registered.
REQ-008 dev_res_in  input  device_res_t  response from PLIC.
REQ-009 lsu_res_out  output  device_res_t  response to LSU; registered.
REQ-010 lsu_res_timeout  output  1  qualifies lsu_res_out: the read timed out.
REQ-011 busy  output  1  FIFO non-empty or state not IDLE.

Function
REQ-012 lsu_req_ready SHALL be 1 iff count < DEPTH, with no combinational path from pop to ready.
REQ-013 A push SHALL occur iff lsu_req_in.valid && lsu_req_ready; lsu_req_in.valid while ready=0 is dropped, and the LSU must hold it.
REQ-014 The FIFO SHALL store id, paddr, is_write and data; pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-015 FSM states SHALL be IDLE and WAIT_RES.
REQ-016 IDLE with FIFO non-empty: pop the head; next cycle dev_req_out = head with valid=1 for exactly one cycle.
REQ-017 After a write issue the state SHALL stay IDLE, with no response to the LSU (fire-and-forget).
REQ-018 After a read issue the state SHALL go to WAIT_RES, latch the id, and clear the wait counter.
REQ-019 At most one read SHALL be outstanding, and no issue SHALL occur in WAIT_RES.
REQ-020 In WAIT_RES, when dev_res_in.valid and the id matches, the next cycle SHALL present lsu_res_out = dev_res_in (valid=1, one cycle) with timeout=0, and the state returns to IDLE.
REQ-021 In WAIT_RES, a dev_res_in.valid with a mismatched id SHALL be discarded without changing state.
REQ-022 In IDLE, any dev_res_in.valid SHALL be discarded.
REQ-023 In WAIT_RES the wait counter SHALL increment each cycle without a matching response.
REQ-024 On reaching TIMEOUT, the next cycle SHALL present lsu_res_out valid=1 with the latched id, data=0, and lsu_res_timeout=1; the state returns to IDLE.
REQ-025 A matching response arriving in the same cycle the counter reaches TIMEOUT SHALL take precedence over the timeout.
REQ-026 Minimum read latency: push at edge T, dev_req_out valid after edge T+1, PLIC response after edge T+2, lsu_res_out valid after edge T+3.
REQ-027 Back-to-back writes SHALL issue on consecutive cycles.
REQ-028 Counter width SHALL be $clog2(TIMEOUT+1); it never wraps.

Reset
REQ-029 On reset: FIFO empty, pointers 0, state IDLE, counter 0, dev_req_out='0, lsu_res_out='0, lsu_res_timeout=0, busy=0, lsu_req_ready=1.
REQ-030 Reset mid-operation SHALL discard all queued and outstanding requests; a PLIC response arriving after reset deassertion is discarded per REQ-022.

Structure
REQ-031 device_req_t, device_res_t, PADDR_WIDTH and the id width SHALL come from the shared package; a new enum mmio_q_state_t {IDLE, WAIT_RES} SHALL be added there.
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-033 Write then read: push write 0x0c00_0028 data 1, then read 0x0c00_0028. Required: dev_req_out pulses 2 cycles apart; response data 1 forwarded 1 cycle after dev_res_in.
REQ-034 Fill: push 5 writes on consecutive cycles with the device stalled in WAIT_RES by a prior read. Required: ready=0 after the 4th push, and the 5th is not accepted.
REQ-035 Timeout: read with no device response. Required: lsu_res_out valid exactly TIMEOUT+1 cycles after issue, data 0, timeout=1, id matching.
REQ-036 Stray response: dev_res_in id=7 while waiting on id=3, then id=3 data 0xA. Required: one LSU response only, id 3, data 0xA.
REQ-037 Claim read at 0x0c20_1004 then complete write of 10. Required: read returns 10, and the write issues only after the read response.
REQ-038 Reset asserted in WAIT_RES with 2 entries queued. Required: all outputs zero immediately; no issue afterwards until a new push.

Source files
------------

// File: rtl/mmio_req_queue_pkg.sv
// Shared types for the MMIO request queue that sits between the LSU and the PLIC.
// Provides the device request/response structs, the queue FSM state enum, the
// FIFO payload layout (a request without its valid strobe) and a helper that
// turns a stored payload back into an issuable request.
package mmio_req_queue_pkg;

    localparam int PADDR_WIDTH = 32;
    localparam int ID_WIDTH    = 4;
    localparam int DATA_WIDTH  = 32;

    typedef struct packed {
        logic                   valid;
        logic [ID_WIDTH-1:0]    id;
        logic [PADDR_WIDTH-1:0] paddr;
        logic                   is_write;
        logic [DATA_WIDTH-1:0]  data;
    } device_req_t;

    typedef struct packed {
        logic                   valid;
        logic [ID_WIDTH-1:0]    id;
        logic [DATA_WIDTH-1:0]  data;
    } device_res_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RES = 1'b1
    } mmio_q_state_t;

    // What the FIFO actually stores: everything but the valid strobe.
    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [PADDR_WIDTH-1:0] paddr;
        logic                   is_write;
        logic [DATA_WIDTH-1:0]  data;
    } req_payload_t;

    function automatic device_req_t to_req(req_payload_t p);
        return '{valid: 1'b1, id: p.id, paddr: p.paddr, is_write: p.is_write, data: p.data};
    endfunction

endpackage

// File: rtl/mmio_req_queue_if.sv
// Bus bundle for mmio_req_queue.
//   lsu_req_in      LSU -> queue   request; valid is the push strobe
//   lsu_req_ready   queue -> LSU   queue can take a request this cycle
//   dev_req_out     queue -> PLIC  issued request, valid for one cycle
//   dev_res_in      PLIC -> queue  read response
//   lsu_res_out     queue -> LSU   read response (or timeout), valid for one cycle
//   lsu_res_timeout queue -> LSU   qualifies lsu_res_out as a timeout
//   busy            queue -> LSU   work queued or a read outstanding
// Handshake: a request transfers on a rising edge where lsu_req_in.valid and
// lsu_req_ready are both 1; valid while ready is 0 transfers nothing and the
// LSU must hold the request. dev_req_out, dev_res_in and lsu_res_out carry no
// back-pressure: each valid cycle is exactly one transfer.
interface mmio_req_queue_if;
    import mmio_req_queue_pkg::*;

    device_req_t lsu_req_in;
    logic        lsu_req_ready;
    device_req_t dev_req_out;
    device_res_t dev_res_in;
    device_res_t lsu_res_out;
    logic        lsu_res_timeout;
    logic        busy;

    // Queue side.
    modport slave (
        input  lsu_req_in,
        input  dev_res_in,
        output lsu_req_ready,
        output dev_req_out,
        output lsu_res_out,
        output lsu_res_timeout,
        output busy
    );

    // LSU/PLIC side (driver or testbench).
    modport master (
        output lsu_req_in,
        output dev_res_in,
        input  lsu_req_ready,
        input  dev_req_out,
        input  lsu_res_out,
        input  lsu_res_timeout,
        input  busy
    );
endinterface

// File: rtl/mmio_req_queue_fifo.sv
// sync_fifo: single-clock FIFO, registered occupancy count.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   i_push, i_push_data  write strobe/data; ignored when full
//   i_pop            read strobe; ignored when empty
//   o_pop_data       head entry (valid when not empty)
//   o_full, o_empty, o_count  occupancy, all derived from registered state
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule

// File: rtl/mmio_req_queue.sv
// mmio_req_queue: buffers LSU MMIO requests and issues them one at a time to
// the PLIC. Writes are fire-and-forget; a read blocks further issue until the
// matching response arrives or the wait counter hits TIMEOUT, in which case a
// zero-data response flagged with lsu_res_timeout goes back to the LSU.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   io_bus         request/response bundle (slave side), see mmio_req_queue_if
//   o_dbg_state    current FSM state, for observation only
module mmio_req_queue
    import mmio_req_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                clock,
    input  logic                reset,
    mmio_req_queue_if.slave     io_bus,
    output mmio_q_state_t       o_dbg_state
);

    localparam int PL_W  = $bits(req_payload_t);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int FC_W  = $clog2(DEPTH + 1);

    mmio_q_state_t    r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [CNT_W-1:0] r_cnt;
    device_req_t      r_dev_req;
    device_res_t      r_lsu_res;
    logic             r_timeout;

    req_payload_t     w_push_data;
    req_payload_t     w_head;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [FC_W-1:0]  w_count;
    logic             w_res_match;

    assign w_push_data = '{id:       io_bus.lsu_req_in.id,
                           paddr:    io_bus.lsu_req_in.paddr,
                           is_write: io_bus.lsu_req_in.is_write,
                           data:     io_bus.lsu_req_in.data};

    // Pop only depends on registered state, and ready only on the registered
    // count, so there is no combinational path from pop to ready.
    assign w_pop = (r_state == IDLE) && !w_empty;

    sync_fifo #(
        .WIDTH (PL_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (io_bus.lsu_req_in.valid),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign w_res_match = io_bus.dev_res_in.valid && (io_bus.dev_res_in.id == r_id);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_cnt     <= '0;
            r_dev_req <= '0;
            r_lsu_res <= '0;
            r_timeout <= 1'b0;
        end else begin
            // Output strobes are single-cycle pulses.
            r_dev_req <= '0;
            r_lsu_res <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Responses arriving here are stale and ignored.
                    if (w_pop) begin
                        r_dev_req <= to_req(w_head);
                        if (!w_head.is_write) begin
                            r_state <= WAIT_RES;
                            r_id    <= w_head.id;
                            r_cnt   <= '0;
                        end
                    end
                end
                WAIT_RES: begin
                    // A matching response wins over a timeout in the same cycle.
                    if (w_res_match) begin
                        r_lsu_res <= '{valid: 1'b1,
                                       id:    io_bus.dev_res_in.id,
                                       data:  io_bus.dev_res_in.data};
                        r_state   <= IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_lsu_res <= '{valid: 1'b1, id: r_id, data: '0};
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.lsu_req_ready   = !w_full;
    assign io_bus.dev_req_out     = r_dev_req;
    assign io_bus.lsu_res_out     = r_lsu_res;
    assign io_bus.lsu_res_timeout = r_timeout;
    assign io_bus.busy            = (w_count != '0) || (r_state != IDLE);
    assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_mmio_req_queue.sv
// Directed testbench for mmio_req_queue. Issued requests and LSU responses are
// predicted into queues when stimulus is driven and checked as they appear.
module tb_mmio_req_queue;
    import mmio_req_queue_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;
    localparam int REQ_W   = $bits(device_req_t);
    localparam int RES_W   = $bits(device_res_t) + 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mmio_q_state_t dbg_state;
    mmio_req_queue_if bus_if();

    mmio_req_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_bus      (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int n_issue = 0;
    int n_res = 0;
    int issue_cyc = 0;
    int res_cyc = 0;
    int dres_cyc = 0;
    int push_cyc = 0;
    int issue_log[$];
    logic [REQ_W-1:0] exp_req_q[$];
    logic [RES_W-1:0] exp_res_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus_if.dev_res_in.valid) dres_cyc = cyc;
            if (bus_if.dev_req_out.valid) begin
                n_issue++;
                issue_cyc = cyc;
                issue_log.push_back(cyc);
                chk("issue_expected", exp_req_q.size() != 0, 1'b1);
                if (exp_req_q.size() != 0) chk("dev_req_out", bus_if.dev_req_out, exp_req_q.pop_front());
            end
            if (bus_if.lsu_res_out.valid) begin
                n_res++;
                res_cyc = cyc;
                chk("res_expected", exp_res_q.size() != 0, 1'b1);
                if (exp_res_q.size() != 0)
                    chk("lsu_res_out", {bus_if.lsu_res_timeout, bus_if.lsu_res_out}, exp_res_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (start and end at posedge + 1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_req(input logic is_wr, input logic [ID_WIDTH-1:0] req_id,
                            input logic [PADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data,
                            input logic exp_accept);
        device_req_t r;
        r = '{valid: 1'b1, id: req_id, paddr: addr, is_write: is_wr, data: data};
        bus_if.lsu_req_in = r;
        chk("lsu_req_ready", bus_if.lsu_req_ready, exp_accept);
        if (exp_accept) exp_req_q.push_back(r);
        @(posedge clock);
        #1;
        push_cyc = cyc;
        bus_if.lsu_req_in = '0;
    endtask

    task automatic send_res(input logic [ID_WIDTH-1:0] res_id, input logic [DATA_WIDTH-1:0] data,
                            input logic exp_match);
        device_res_t r;
        r = '{valid: 1'b1, id: res_id, data: data};
        bus_if.dev_res_in = r;
        if (exp_match) exp_res_q.push_back({1'b0, r});
        @(posedge clock);
        #1;
        bus_if.dev_res_in = '0;
    endtask

    task automatic expect_timeout(input logic [ID_WIDTH-1:0] res_id);
        device_res_t r;
        r = '{valid: 1'b1, id: res_id, data: '0};
        exp_res_q.push_back({1'b1, r});
    endtask

    task automatic wait_issue(input int target, input int budget, input string tag);
        int n = 0;
        while (n_issue < target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, n_issue >= target, 1'b1);
    endtask

    task automatic wait_res(input int target, input int budget, input string tag);
        int n = 0;
        while (n_res < target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(tag, n_res >= target, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int rbase;
        int t_issue;
        bus_if.lsu_req_in = '0;
        bus_if.dev_res_in = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        chk("rst_ready", bus_if.lsu_req_ready, 1'b1);
        chk("rst_dev_req", bus_if.dev_req_out, '0);
        chk("rst_lsu_res", bus_if.lsu_res_out, '0);
        chk("rst_timeout", bus_if.lsu_res_timeout, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        reset = 1'b0;
        idle(1);

        // Write then read, one idle cycle between pushes
        base = n_issue;
        rbase = n_res;
        push_req(1'b1, 4'd1, 32'h0c00_0028, 32'd1, 1'b1);
        idle(1);
        push_req(1'b0, 4'd2, 32'h0c00_0028, 32'd0, 1'b1);
        wait_issue(base + 2, 10, "t1_issue");
        chk("t1_issue_gap", issue_log[base + 1] - issue_log[base], 2);
        chk("t1_rd_latency", issue_cyc, push_cyc + 1);
        chk("t1_busy_wait", bus_if.busy, 1'b1);
        send_res(4'd2, 32'd1, 1'b1);
        wait_res(rbase + 1, 10, "t1_res");
        chk("t1_res_latency", res_cyc, dres_cyc + 1);

        // Claim read then complete write: the write waits for the read response
        base = n_issue;
        rbase = n_res;
        push_req(1'b0, 4'd3, 32'h0c20_1004, 32'd0, 1'b1);
        push_req(1'b1, 4'd4, 32'h0c20_1004, 32'd10, 1'b1);
        wait_issue(base + 1, 10, "t2_rd_issue");
        idle(5);
        chk("t2_write_held", n_issue, base + 1);
        chk("t2_state_wait", dbg_state, WAIT_RES);
        send_res(4'd3, 32'd10, 1'b1);
        wait_res(rbase + 1, 10, "t2_res");
        wait_issue(base + 2, 10, "t2_wr_issue");
        chk("t2_wr_after_res", issue_cyc, res_cyc + 1);

        // Stray response id 7 while waiting on id 3
        base = n_issue;
        rbase = n_res;
        push_req(1'b0, 4'd3, 32'h0c20_1008, 32'd0, 1'b1);
        wait_issue(base + 1, 10, "t3_issue");
        send_res(4'd7, 32'h55, 1'b0);
        idle(2);
        chk("t3_stray_state", dbg_state, WAIT_RES);
        chk("t3_stray_nores", n_res, rbase);
        send_res(4'd3, 32'hA, 1'b1);
        wait_res(rbase + 1, 10, "t3_res");
        idle(3);
        chk("t3_one_res", n_res, rbase + 1);

        // Response while IDLE is discarded
        rbase = n_res;
        send_res(4'd5, 32'h99, 1'b0);
        idle(3);
        chk("t4_idle_nores", n_res, rbase);
        chk("t4_busy", bus_if.busy, 1'b0);

        // Fill the FIFO behind a stalled read
        base = n_issue;
        rbase = n_res;
        push_req(1'b0, 4'd1, 32'h0c00_0004, 32'd0, 1'b1);
        wait_issue(base + 1, 10, "t5_rd_issue");
        for (int i = 0; i < 5; i++)
            push_req(1'b1, 4'(8 + i), 32'h0c00_0100 + 32'(4 * i), 32'(i), i < 4);
        chk("t5_ready_full", bus_if.lsu_req_ready, 1'b0);
        idle(3);
        chk("t5_no_issue", n_issue, base + 1);
        send_res(4'd1, 32'h1234, 1'b1);
        wait_res(rbase + 1, 10, "t5_res");
        wait_issue(base + 5, 20, "t5_wr_issue");
        chk("t5_first_wr", issue_log[base + 1], res_cyc + 1);
        chk("t5_back_to_back", issue_log[base + 4] - issue_log[base + 1], 3);
        idle(5);
        chk("t5_fifth_dropped", n_issue, base + 5);
        chk("t5_ready_again", bus_if.lsu_req_ready, 1'b1);

        // Timeout with no device response
        base = n_issue;
        rbase = n_res;
        push_req(1'b0, 4'd6, 32'h0c00_0200, 32'd0, 1'b1);
        expect_timeout(4'd6);
        wait_issue(base + 1, 10, "t6_issue");
        t_issue = issue_cyc;
        wait_res(rbase + 1, TIMEOUT + 10, "t6_res");
        chk("t6_latency", res_cyc - t_issue, TIMEOUT + 1);
        idle(1);
        chk("t6_timeout_clear", bus_if.lsu_res_timeout, 1'b0);
        chk("t6_state_idle", dbg_state, IDLE);

        // Matching response in the same cycle the counter reaches TIMEOUT
        base = n_issue;
        rbase = n_res;
        push_req(1'b0, 4'd2, 32'h0c00_0204, 32'd0, 1'b1);
        wait_issue(base + 1, 10, "t7_issue");
        t_issue = issue_cyc;
        while (cyc < t_issue + TIMEOUT) idle(1);
        send_res(4'd2, 32'h77, 1'b1);
        wait_res(rbase + 1, 10, "t7_res");
        chk("t7_res_cycle", res_cyc, t_issue + TIMEOUT + 1);
        idle(3);
        chk("t7_one_res", n_res, rbase + 1);

        // Reset in WAIT_RES with two writes queued
        base = n_issue;
        push_req(1'b0, 4'd1, 32'h0c00_0208, 32'd0, 1'b1);
        wait_issue(base + 1, 10, "t8_issue");
        push_req(1'b1, 4'd2, 32'h0c00_020c, 32'd2, 1'b1);
        push_req(1'b1, 4'd3, 32'h0c00_0210, 32'd3, 1'b1);
        reset = 1'b1;
        #1;
        chk("t8_rst_dev_req", bus_if.dev_req_out, '0);
        chk("t8_rst_lsu_res", bus_if.lsu_res_out, '0);
        chk("t8_rst_timeout", bus_if.lsu_res_timeout, 1'b0);
        chk("t8_rst_busy", bus_if.busy, 1'b0);
        chk("t8_rst_ready", bus_if.lsu_req_ready, 1'b1);
        chk("t8_rst_state", dbg_state, IDLE);
        exp_req_q.delete();
        exp_res_q.delete();
        idle(2);
        reset = 1'b0;
        base = n_issue;
        rbase = n_res;
        send_res(4'd1, 32'h5, 1'b0);
        idle(8);
        chk("t8_no_issue", n_issue, base);
        chk("t8_no_res", n_res, rbase);
        push_req(1'b1, 4'd9, 32'h0c00_0300, 32'hBEEF, 1'b1);
        wait_issue(base + 1, 10, "t8_new_issue");
        idle(3);

        chk("end_req_q_empty", exp_req_q.size(), 0);
        chk("end_res_q_empty", exp_res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
